// File: rtl/adder_pkg.sv
// Shared state type and sizing helpers for the serial chunk adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int calc_nch(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    // Index register width; a single-chunk build still needs one bit.
    function automatic int idx_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/chunk_full_adder.sv
// Combinational CHUNK-bit full adder; the multi-bit form of the 1-bit full-adder cell.
module chunk_full_adder #(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle add/subtract, CHUNK bits per clock through one registered carry.
// Optional signed-overflow output enabled by defining SERIAL_CHUNK_ADDER_OVF_EN.
module serial_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCH = calc_nch(WIDTH, CHUNK);
    localparam int IW  = idx_width(NCH);
    localparam logic [IW-1:0]    LAST_IDX   = IW'(NCH - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("serial_chunk_adder: CHUNK must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, work_q, work_d, sum_q, sum_d;
    logic             co_q, co_d;
    logic             busy_q, done_q;
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    int               base_s;
    logic [CHUNK-1:0] x_s, y_s, s_s;
    logic             cout_s;
    logic [WIDTH-1:0] work_ins_s;

    // Slice the current chunk out of the latched operands and merge the result back.
    always_comb begin
        base_s     = int'(idx_q) * CHUNK;
        x_s        = CHUNK'(a_q >> base_s);
        y_s        = CHUNK'(b_q >> base_s);
        work_ins_s = (work_q & ~(CHUNK_MASK << base_s)) | (WIDTH'(s_s) << base_s);
    end

    chunk_full_adder #(.CHUNK(CHUNK)) u_cfa (
        .x    (x_s),
        .y    (y_s),
        .cin  (carry_q),
        .s    (s_s),
        .cout (cout_s)
    );

    // Next-state logic; subtraction is folded in at latch time via inverted b and ci.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        co_d    = co_q;
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? ~ci : ci;
                    idx_d   = {IW{1'b0}};
                    work_d  = {WIDTH{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                work_d  = work_ins_s;
                carry_d = cout_s;
                if (idx_q == LAST_IDX) begin
                    idx_d   = {IW{1'b0}};
                    sum_d   = work_ins_s;
                    co_d    = cout_s;
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
                    // Carry into the MSB is recovered from the MSB sum bit.
                    ovf_d   = x_s[CHUNK-1] ^ y_s[CHUNK-1] ^ s_s[CHUNK-1] ^ cout_s;
`endif
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= {IW{1'b0}};
            carry_q <= 1'b0;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            work_q  <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign co   = co_q;
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Randomised bench for serial_chunk_adder: CHUNK=1 and CHUNK=4 instances against an integer model.
module tb_serial_chunk_adder;

    logic       clk;
    logic       rst;
    logic       start_s [2];
    logic [7:0] a_s, b_s;
    logic       ci_s, sub_s;
    logic       busy_s [2];
    logic       done_s [2];
    logic [7:0] sum_s  [2];
    logic       co_s   [2];
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
    logic       ovf_s  [2];
`endif

    logic [7:0] last_sum [2];
    logic       last_co  [2];
    logic       last_ovf [2];

    int n_checks = 0;
    int n_fail   = 0;

    serial_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_dut_c1 (
        .clk(clk), .rst(rst), .start(start_s[0]), .a(a_s), .b(b_s), .ci(ci_s), .sub(sub_s),
        .busy(busy_s[0]), .done(done_s[0]), .sum(sum_s[0]), .co(co_s[0])
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
        , .ovf(ovf_s[0])
`endif
    );

    serial_chunk_adder #(.WIDTH(8), .CHUNK(4)) u_dut_c4 (
        .clk(clk), .rst(rst), .start(start_s[1]), .a(a_s), .b(b_s), .ci(ci_s), .sub(sub_s),
        .busy(busy_s[1]), .done(done_s[1]), .sum(sum_s[1]), .co(co_s[1])
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
        , .ovf(ovf_s[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for sum/co, signed for ovf.
    task automatic ref_op(input logic [7:0] av, input logic [7:0] bv, input logic civ,
                          input logic subv, output logic [7:0] esum, output logic eco,
                          output logic eovf);
        int d, sd, sa, sb;
        sa = int'($signed(av));
        sb = int'($signed(bv));
        if (subv) begin
            d   = int'(av) - int'(bv) - int'(civ);
            sd  = sa - sb - int'(civ);
            eco = (d >= 0);
        end else begin
            d   = int'(av) + int'(bv) + int'(civ);
            sd  = sa + sb + int'(civ);
            eco = (d > 255);
        end
        esum = 8'(d);
        eovf = (sd > 127) || (sd < -128);
    endtask

    task automatic run_op(input int u, input logic [7:0] av, input logic [7:0] bv,
                          input logic civ, input logic subv, input int glitch_at);
        int         nch, cyc, busy_cyc;
        bit         seen;
        logic [7:0] esum;
        logic       eco, eovf;
        nch = (u == 0) ? 8 : 2;
        ref_op(av, bv, civ, subv, esum, eco, eovf);
        @(negedge clk);
        check_eq("idle_busy", 32'(busy_s[u]), 32'd0);
        check_eq("idle_done", 32'(done_s[u]), 32'd0);
        a_s = av; b_s = bv; ci_s = civ; sub_s = subv;
        start_s[u] = 1'b1;
        @(posedge clk);
        #1;
        start_s[u] = 1'b0;
        a_s = 8'($urandom); b_s = 8'($urandom); ci_s = 1'($urandom); sub_s = 1'($urandom);
        cyc = 0; busy_cyc = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start_s[u] = (cyc == glitch_at);
            if (cyc == glitch_at) begin
                a_s = 8'($urandom); b_s = 8'($urandom);
            end
            if (busy_s[u]) busy_cyc++;
            if (done_s[u]) begin
                seen = 1'b1;
                check_eq("latency", 32'(cyc), 32'(nch + 1));
                check_eq("sum", 32'(sum_s[u]), 32'(esum));
                check_eq("co", 32'(co_s[u]), 32'(eco));
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
                check_eq("ovf", 32'(ovf_s[u]), 32'(eovf));
`endif
            end else begin
                check_eq("sum_hold", 32'(sum_s[u]), 32'(last_sum[u]));
                check_eq("co_hold", 32'(co_s[u]), 32'(last_co[u]));
            end
        end
        start_s[u] = 1'b0;
        if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
        check_eq("busy_cycles", 32'(busy_cyc), 32'(nch + 1));
        last_sum[u] = esum; last_co[u] = eco; last_ovf[u] = eovf;
        if (glitch_at > 0) begin
            repeat (2) begin
                @(negedge clk);
                check_eq("no_extra_done", 32'(done_s[u]), 32'd0);
                check_eq("no_extra_busy", 32'(busy_s[u]), 32'd0);
            end
        end
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        a_s = 8'h3C; b_s = 8'h5A; ci_s = 1'b1; sub_s = 1'b0;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            check_eq("rst_busy", 32'(busy_s[u]), 32'd0);
            check_eq("rst_done", 32'(done_s[u]), 32'd0);
            check_eq("rst_sum", 32'(sum_s[u]), 32'd0);
            check_eq("rst_co", 32'(co_s[u]), 32'd0);
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
            check_eq("rst_ovf", 32'(ovf_s[u]), 32'd0);
`endif
            last_sum[u] = 8'h00; last_co[u] = 1'b0; last_ovf[u] = 1'b0;
        end
        repeat (10) begin
            @(negedge clk);
            check_eq("no_done_after_rst", 32'(done_s[0]), 32'd0);
        end
    endtask

    initial begin
        int u, g;
        rst = 1'b1;
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        a_s = 8'h00; b_s = 8'h00; ci_s = 1'b0; sub_s = 1'b0;
        for (int i = 0; i < 2; i++) begin
            last_sum[i] = 8'h00; last_co[i] = 1'b0; last_ovf[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq("reset_busy", 32'(busy_s[i]), 32'd0);
            check_eq("reset_done", 32'(done_s[i]), 32'd0);
            check_eq("reset_sum", 32'(sum_s[i]), 32'd0);
            check_eq("reset_co", 32'(co_s[i]), 32'd0);
        end
        rst = 1'b0;

        run_op(0, 8'h01, 8'hFF, 1'b0, 1'b0, 0);
        run_op(1, 8'h05, 8'h03, 1'b1, 1'b1, 0);
        run_op(1, 8'h03, 8'h05, 1'b0, 1'b1, 0);
        run_op(0, 8'h5A, 8'h33, 1'b1, 1'b0, 4);
        run_op(1, 8'hC4, 8'h17, 1'b0, 1'b1, 1);
        reset_mid_run();
        run_op(0, 8'h3C, 8'h5A, 1'b1, 1'b0, 0);
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 0);
        run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 0);
        run_op(1, 8'h10, 8'h20, 1'b0, 1'b0, 0);
        run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 0);
        run_op(1, 8'h80, 8'h01, 1'b0, 1'b1, 0);
        run_op(0, 8'hFF, 8'hFF, 1'b1, 1'b0, 0);
        run_op(0, 8'h00, 8'hFF, 1'b1, 1'b1, 0);

        for (int i = 0; i < 24; i++) begin
            u = int'($urandom_range(0, 1));
            g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, (u == 0) ? 8 : 2)) : 0;
            run_op(u, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), g);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
